data_mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the data memory port. It sits between the CPU load/store path, the DMA/debug load/store path and the single `data_mem` instance. It grants one requester at a time using round-robin, and drives `data_mem`'s strobe/stall protocol on the winner's behalf. It returns read data or a timeout error to that requester with a one-cycle acknowledge.

---
 rtl/data_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Round-robin arbiter and access sequencer between two load/store requesters
// (CPU and DMA/debug) and the single data_mem port. The winner's address,
// write data and mask are latched onto the memory port at the grant edge. The
// block then issues a one-cycle read/write strobe and follows data_mem's
// clk_stall high/low handshake. It returns read data, or a timeout error when
// the stall never rises, with a one-cycle acknowledge. All outputs are
// registered.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata/mask CPU request (held until cpu_ack)
//   cpu_ack/err/rdata          CPU completion pulse, timeout flag, read data
//   dma_*                      same set for the DMA requester
//   mem_addr/write_data/
//   sign_mask                  latched access fields to data_mem
//   mem_memread/memwrite       one-cycle strobes to data_mem
//   mem_read_data, 
//   mem_clk_stall              responses from data_mem
//   busy                       high whenever the sequencer is not idle
//   grant_id                   owner of the current/last grant (0 CPU, 1 DMA)
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_mask,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_mask,
    output logic        dma_ack,
    output logic        dma_err,
    output logic [31:0] dma_rdata,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memread,
    output logic        mem_memwrite,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall,

    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DONE
    } state_e;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        grant_q, grant_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        cpu_err_q, cpu_err_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic        dma_ack_q, dma_ack_d;
    logic        dma_err_q, dma_err_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;
    logic        busy_q, busy_d;

    logic        win_dma;
    logic [7:0]  cnt_inc;

    // Under contention the requester that did not win last time goes next.
    assign win_dma = (cpu_req && dma_req) ? ~last_q : dma_req;
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        // NOTE: every next-state signal is given a default before the case so
        // no path leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        cpu_ack_d   = 1'b0;
        cpu_err_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_ack_d   = 1'b0;
        dma_err_d   = 1'b0;
        dma_rdata_d = dma_rdata_q;

        case (state_q)
            S_IDLE: begin
                // The stall guard keeps us from starting while an access that
                // was cut short by reset is still running inside data_mem.
                if ((cpu_req || dma_req) && !mem_clk_stall) begin
                    grant_d = win_dma;
                    last_d  = win_dma;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                    if (win_dma) begin
                        we_d    = dma_we;
                        addr_d  = dma_addr;
                        wdata_d = dma_wdata;
                        mask_d  = dma_mask;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                        mask_d  = cpu_mask;
                    end
                    rd_d = ~we_d;
                    wr_d = we_d;
                end
            end

            // Strobes fall back to 0 by default: one-cycle pulse.
            S_ISSUE: state_d = S_WAIT_HI;

            S_WAIT_HI: begin
                if (mem_clk_stall) begin
                    state_d = S_WAIT_LO;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_CNT) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_WAIT_LO: begin
                if (!mem_clk_stall) begin
                    state_d = S_IDLE;
                    if (grant_q) begin
                        dma_ack_d = 1'b1;
                        if (!we_q) dma_rdata_d = mem_read_data;
                    end else begin
                        cpu_ack_d = 1'b1;
                        if (!we_q) cpu_rdata_d = mem_read_data;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                if (grant_q) begin
                    dma_ack_d = 1'b1;
                    dma_err_d = 1'b1;
                end else begin
                    cpu_ack_d = 1'b1;
                    cpu_err_d = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            grant_q     <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_ack_q   <= 1'b0;
            dma_err_q   <= 1'b0;
            dma_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_ack_q   <= dma_ack_d;
            dma_err_q   <= dma_err_d;
            dma_rdata_q <= dma_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign cpu_ack        = cpu_ack_q;
    assign cpu_err        = cpu_err_q;
    assign cpu_rdata      = cpu_rdata_q;
    assign dma_ack        = dma_ack_q;
    assign dma_err        = dma_err_q;
    assign dma_rdata      = dma_rdata_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_sign_mask  = mask_q;
    assign mem_memread    = rd_q;
    assign mem_memwrite   = wr_q;
    assign busy           = busy_q;
    assign grant_id       = grant_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Bench for data_mem_arbiter. It contains a small data_mem stand-in that
// raises clk_stall for a chosen number of cycles after each strobe, or never
// when nostall is set. A transaction-level reference predicts every output:
// each grant fixes its completion edge as grant+2+stall_len, or
// grant+TIMEOUT+2 when the memory never answers. The main process compares
// the DUT against that prediction on every falling edge. It also runs
// directed scenarios with hand-computed literal expectations and a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [3:0]  cpu_mask, dma_mask;
    logic        cpu_ack, cpu_err, dma_ack, dma_err;
    logic [31:0] cpu_rdata, dma_rdata;
    logic [31:0] mem_addr, mem_write_data;
    logic [3:0]  mem_sign_mask;
    logic        mem_memread, mem_memwrite;
    logic [31:0] mem_read_data = 32'h0;
    logic        mem_clk_stall = 1'b0;
    logic        busy, grant_id;

    data_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_mask(cpu_mask),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_mask(dma_mask),
        .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_sign_mask(mem_sign_mask), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_read_data(mem_read_data),
        .mem_clk_stall(mem_clk_stall), .busy(busy), .grant_id(grant_id)
    );

    // Environment knobs, written only by the main process.
    bit nostall   = 1'b0;
    int force_len = 1;        // 0 selects a random stall length 1..4

    // Initial memory image shared by the memory stand-in and the reference.
    function automatic logic [31:0] init_word(int idx);
        if (idx == 'h1000) return 32'h11223344;
        return 32'hC0DE0000 | 32'(idx);
    endfunction

    // ---------------- data_mem stand-in ----------------
    logic [31:0] mem_arr [int];
    int          stall_left   = 0;
    int          mem_len_next = 1;   // chosen by the reference at grant time
    int          mem_idx;

    always @(posedge clk) begin
        if (stall_left > 0) begin
            stall_left = stall_left - 1;
            if (stall_left == 0) mem_clk_stall <= 1'b0;
        end else if (!nostall && (mem_memread || mem_memwrite)) begin
            mem_idx       = int'(mem_addr[15:2]);
            mem_clk_stall <= 1'b1;
            stall_left    = mem_len_next;
            if (mem_memwrite) mem_arr[mem_idx] = mem_write_data;
            else mem_read_data <= mem_arr.exists(mem_idx) ? mem_arr[mem_idx]
                                                          : init_word(mem_idx);
        end
    end

    // ---------------- transaction-level reference ----------------
    logic [31:0] ref_mem [int];
    int          m_edge = 0;
    bit          m_inflight, m_timeout, m_owner, m_we, m_last, m_gid;
    int          m_done_at;
    logic [31:0] m_rval, m_addr, m_wdata;
    logic [3:0]  m_mask;
    logic [1:0]  m_ack, m_err;
    logic        m_rd, m_wr, m_busy;
    logic [31:0] m_rdata [2];
    int          m_len, m_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_inflight = 0; m_last = 1; m_gid = 1;
            m_addr = 0; m_wdata = 0; m_mask = 0;
            m_rd = 0; m_wr = 0; m_ack = 0; m_err = 0; m_busy = 0;
            m_rdata[0] = 0; m_rdata[1] = 0;
        end else begin
            m_edge = m_edge + 1;
            m_rd = 0; m_wr = 0; m_ack = 0; m_err = 0;
            if (m_inflight) begin
                if (m_edge == m_done_at) begin
                    m_inflight     = 0;
                    m_ack[m_owner] = 1'b1;
                    m_err[m_owner] = m_timeout;
                    if (!m_timeout && !m_we) m_rdata[m_owner] = m_rval;
                end
            end else if ((cpu_req || dma_req) && !mem_clk_stall) begin
                m_owner = (cpu_req && dma_req) ? !m_last : dma_req;
                m_last  = m_owner;
                m_gid   = m_owner;
                m_we    = m_owner ? dma_we    : cpu_we;
                m_addr  = m_owner ? dma_addr  : cpu_addr;
                m_wdata = m_owner ? dma_wdata : cpu_wdata;
                m_mask  = m_owner ? dma_mask  : cpu_mask;
                m_rd    = !m_we;
                m_wr    = m_we;
                m_idx   = int'(m_addr[15:2]);
                m_rval  = ref_mem.exists(m_idx) ? ref_mem[m_idx] : init_word(m_idx);
                if (m_we && !nostall) ref_mem[m_idx] = m_wdata;
                m_len        = (force_len > 0) ? force_len : int'($urandom_range(1, 4));
                mem_len_next = m_len;
                m_timeout    = nostall;
                m_done_at    = m_edge + (nostall ? TIMEOUT + 2 : 2 + m_len);
                m_inflight   = 1;
            end
            m_busy = m_inflight;
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0, n_fail = 0, ncyc = 0;
    int n_rd = 0, n_cpu_acks = 0, n_dma_acks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, ncyc, act, exp);
        end
    endtask

    // One cycle: wait for the falling edge, compare every output with the
    // reference, update event counters.
    task automatic tick();
        @(negedge clk);
        ncyc++;
        if (rst_n) begin
            check("cpu_ack",   cpu_ack,        m_ack[0]);
            check("dma_ack",   dma_ack,        m_ack[1]);
            check("cpu_err",   cpu_err,        m_err[0]);
            check("dma_err",   dma_err,        m_err[1]);
            check("cpu_rdata", cpu_rdata,      m_rdata[0]);
            check("dma_rdata", dma_rdata,      m_rdata[1]);
            check("mem_addr",  mem_addr,       m_addr);
            check("mem_wdata", mem_write_data, m_wdata);
            check("mem_mask",  mem_sign_mask,  m_mask);
            check("memread",   mem_memread,    m_rd);
            check("memwrite",  mem_memwrite,   m_wr);
            check("busy",      busy,           m_busy);
            check("grant_id",  grant_id,       m_gid);
        end
        if (mem_memread) n_rd++;
        if (cpu_ack) n_cpu_acks++;
        if (dma_ack) n_dma_acks++;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_ack"},   cpu_ack,        0);
        check({tag, "_dma_ack"},   dma_ack,        0);
        check({tag, "_cpu_err"},   cpu_err,        0);
        check({tag, "_dma_err"},   dma_err,        0);
        check({tag, "_memread"},   mem_memread,    0);
        check({tag, "_memwrite"},  mem_memwrite,   0);
        check({tag, "_mem_addr"},  mem_addr,       0);
        check({tag, "_mem_wdata"}, mem_write_data, 0);
        check({tag, "_mem_mask"},  mem_sign_mask,  0);
        check({tag, "_cpu_rdata"}, cpu_rdata,      0);
        check({tag, "_dma_rdata"}, dma_rdata,      0);
        check({tag, "_busy"},      busy,           0);
        check({tag, "_grant_id"},  grant_id,       1);
    endtask

    // Count falling edges until the selected ack shows (bounded).
    task automatic wait_ack(input bit which, output int n);
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            tick();
            n++;
            seen = which ? dma_ack : cpu_ack;
        end
        check(which ? "dma_ack_seen" : "cpu_ack_seen", seen, 1);
    endtask

    task automatic cpu_issue(input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] mask);
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_mask = mask; cpu_req = 1'b1;
    endtask

    task automatic dma_issue(input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] mask);
        dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_mask = mask; dma_req = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h4000 + 32'(4 * $urandom_range(0, 15));
    endfunction

    // Random requester behaviour: raise requests at random, and on ack
    // either drop or immediately present a fresh request.
    task automatic rand_step();
        if (cpu_req) begin
            if (cpu_ack) begin
                if ($urandom_range(0, 3) == 0) cpu_issue(1'($urandom), rand_addr(), $urandom, 4'($urandom));
                else cpu_req = 1'b0;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            cpu_issue(1'($urandom), rand_addr(), $urandom, 4'($urandom));
        end
        if (dma_req) begin
            if (dma_ack) begin
                if ($urandom_range(0, 3) == 0) dma_issue(1'($urandom), rand_addr(), $urandom, 4'($urandom));
                else dma_req = 1'b0;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            dma_issue(1'($urandom), rand_addr(), $urandom, 4'($urandom));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rd0, acks, prev_cyc;
        int owners [4];
        int gaps [4];
        logic [31:0] prev_rdata, grant_addr;

        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_mask = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_mask = 0;
        tick();
        tick();
        check_reset_values("rst");
        rst_n = 1'b1;

        // CPU read alone: 3 edges from sampling to ack, one read strobe.
        rd0 = n_rd;
        cpu_issue(1'b0, 32'h4000, 32'h0, 4'b0100);
        wait_ack(1'b0, n);
        cpu_req = 1'b0;
        check("cpuA_latency", n - 1, 3);
        check("cpuA_rdata", cpu_rdata, 32'h11223344);
        check("cpuA_err", cpu_err, 0);
        check("cpuA_rd_pulses", n_rd - rd0, 1);
        check("cpuA_grant", grant_id, 0);

        // DMA write, then CPU read of the same word.
        dma_issue(1'b1, 32'h4004, 32'hDEADBEEF, 4'b1111);
        wait_ack(1'b1, n);
        dma_req = 1'b0;
        check("dmaW_grant", grant_id, 1);
        check("dmaW_err", dma_err, 0);
        cpu_issue(1'b0, 32'h4004, 32'h0, 4'b1111);
        wait_ack(1'b0, n);
        cpu_req = 1'b0;
        check("cpuB_rdata", cpu_rdata, 32'hDEADBEEF);
        check("cpuB_grant", grant_id, 0);

        // Contention from reset: CPU, DMA, CPU, DMA, acks 4 cycles apart.
        do_reset();
        cpu_issue(1'b0, 32'h4008, 32'h0, 4'b1111);
        dma_issue(1'b0, 32'h400C, 32'h0, 4'b1111);
        acks = 0; prev_cyc = 0; n = 0; grant_addr = 0;
        while (acks < 4 && n < 60) begin
            tick();
            n++;
            if (mem_memread) grant_addr = mem_addr;
            if (cpu_ack || dma_ack) begin
                check("cont_addr_stable", mem_addr, grant_addr);
                owners[acks] = dma_ack ? 1 : 0;
                gaps[acks]   = ncyc - prev_cyc;
                prev_cyc     = ncyc;
                acks++;
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        check("cont_acks", acks, 4);
        check("cont_owner0", owners[0], 0);
        check("cont_owner1", owners[1], 1);
        check("cont_owner2", owners[2], 0);
        check("cont_owner3", owners[3], 1);
        check("cont_gap1", gaps[1], 4);
        check("cont_gap2", gaps[2], 4);
        check("cont_gap3", gaps[3], 4);
        tick();

        // Timeout: memory never stalls.
        nostall = 1'b1;
        prev_rdata = cpu_rdata;
        cpu_issue(1'b0, 32'h4010, 32'h0, 4'b1111);
        wait_ack(1'b0, n);
        cpu_req = 1'b0;
        check("tmo_latency", n - 1, TIMEOUT + 2);
        check("tmo_err", cpu_err, 1);
        check("tmo_rdata_kept", cpu_rdata, prev_rdata);
        tick();
        nostall = 1'b0;
        cpu_issue(1'b0, 32'h4000, 32'h0, 4'b1111);
        wait_ack(1'b0, n);
        cpu_req = 1'b0;
        check("post_tmo_latency", n - 1, 3);
        check("post_tmo_err", cpu_err, 0);
        check("post_tmo_rdata", cpu_rdata, 32'h11223344);

        // Reset one cycle after grant while data_mem keeps stalling.
        force_len = 4;
        cpu_issue(1'b0, 32'h4004, 32'h0, 4'b1111);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        cpu_req = 1'b0;
        force_len = 1;
        tick();
        rst_n = 1'b1;
        dma_issue(1'b0, 32'h4000, 32'h0, 4'b1111);
        n = 0;
        while (mem_clk_stall && n < 20) begin
            check("midrst_no_grant", {busy, mem_memread}, 0);
            tick();
            n++;
        end
        check("midrst_stall_ends", mem_clk_stall, 0);
        wait_ack(1'b1, n);
        dma_req = 1'b0;
        check("midrst_rdata", dma_rdata, 32'h11223344);
        check("midrst_err", dma_err, 0);

        // CPU holds req through its ack: two separate accesses.
        rd0 = n_rd;
        acks = n_cpu_acks;
        cpu_issue(1'b0, 32'h4000, 32'h0, 4'b1111);
        wait_ack(1'b0, n);
        cpu_addr = 32'h4004;
        wait_ack(1'b0, n);
        cpu_req = 1'b0;
        check("hold_second_latency", n - 1, 3);
        check("hold_rd_pulses", n_rd - rd0, 2);
        check("hold_acks", n_cpu_acks - acks, 2);
        check("hold_rdata", cpu_rdata, 32'hDEADBEEF);
        tick();

        // Randomized traffic with random stall lengths.
        force_len = 0;
        acks = n_cpu_acks;
        rd0 = n_dma_acks;
        for (int i = 0; i < 3000; i++) begin
            tick();
            rand_step();
        end
        n = 0;
        while ((cpu_req || dma_req || busy) && n < 200) begin
            tick();
            if (cpu_ack) cpu_req = 1'b0;
            if (dma_ack) dma_req = 1'b0;
            n++;
        end
        check("rand_drained", {cpu_req, dma_req, busy}, 0);
        check("rand_cpu_served", 32'(n_cpu_acks - acks > 0), 1);
        check("rand_dma_served", 32'(n_dma_acks - rd0 > 0), 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
